pf_vf_port_encoder: RTL and testbench
=====================================

PF_VF_PORT_ENCODER -- requirements
Module: pf_vf_port_encoder

Interface
REQ-001 SHALL have parameter NUM_PORT, default 4, number of mux ports to encode (>=1).
REQ-002 SHALL have parameter PF_WIDTH, default 3, PF field width.
REQ-003 SHALL have parameter VF_WIDTH, default 11, VF field width.
REQ-004 SHALL have parameter DATA_WIDTH, default 512, opaque payload width; NID_WIDTH = max(1, clog2(NUM_PORT)) is derived.
REQ-005 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports i_valid/i_ready  input/output  1/1  ingress handshake; i_port  input  NID_WIDTH  source mux port; i_data  input  DATA_WIDTH  payload.
REQ-008 SHALL have ports o_valid/o_ready  output/input  1/1  egress handshake; o_pf  output  PF_WIDTH; o_vf  output  VF_WIDTH; o_vf_active  output  1; o_data  output  DATA_WIDTH.
REQ-009 SHALL have table-write ports wr_en  input  1; wr_port  input  NID_WIDTH; wr_valid, wr_vf_active  input  1 each; wr_pf  input  PF_WIDTH; wr_vf  input  VF_WIDTH.
REQ-010 SHALL have outputs init_done  1  table initialised; err_pulse  1  one-cycle unmapped-port drop indication.

Function
REQ-011 SHALL hold a reverse routing table of NUM_PORT entries {valid, pf, vf, vf_active}: port number -> PF/VF, the inverse of the PF/VF MUX routing.
REQ-012 SHALL implement FSM INIT -> RUN; INIT writes entry p = {valid=1, pf=0, vf=p, vf_active=1}, one entry per cycle, p = 0..NUM_PORT-1, then enters RUN; RUN is terminal until reset.
REQ-013 SHALL assert init_done exactly while in RUN (first asserted NUM_PORT cycles after rst_n deasserts).
REQ-014 SHALL drive i_ready = 0 in INIT; in RUN i_ready = (~o_valid | o_ready).
REQ-015 SHALL ignore wr_en in INIT; in RUN a wr_en write updates entry wr_port at the clock edge; wr_port >= NUM_PORT is ignored.
REQ-016 SHALL register lookup result: accepted beat (i_valid & i_ready) with mapped entry produces o_valid=1 the next cycle with o_pf/o_vf/o_vf_active from the entry and o_data = i_data.
REQ-017 SHALL use the pre-write table value when a write and a lookup of the same entry coincide; the write is visible from the next accepted beat.
REQ-018 SHALL drop an accepted beat whose entry has valid=0 or whose i_port >= NUM_PORT: no o_valid, err_pulse=1 for exactly the next cycle.
REQ-019 SHALL hold o_valid and all o_* stable while o_valid & ~o_ready.
REQ-020 SHALL sustain one beat per cycle with o_ready held high; with o_ready low the single output register fills and i_ready drops.
REQ-021 SHALL preserve input order; no reordering or duplication.

Reset
REQ-022 SHALL, on rst_n low, immediately force: FSM=INIT, init index=0, o_valid=0, o_pf=0, o_vf=0, o_vf_active=0, o_data=0, err_pulse=0, init_done=0, i_ready=0, all table entries valid=0.
REQ-023 SHALL discard any in-flight beat when reset asserts mid-operation and restart INIT on deassertion.

Configuration
REQ-024 SHALL compile output err_cnt (16 bits, reset 0) only when PF_VF_PORT_ENCODER_ERR_CNT_EN is defined; it increments on each err_pulse and saturates at 16'hFFFF.
REQ-025 SHALL, without PF_VF_PORT_ENCODER_ERR_CNT_EN, omit the err_cnt port and counter; all other behaviour is identical.

Verification
REQ-026 SHALL cover: release reset, NUM_PORT=4 -> init_done rises 4 cycles later; i_port=2 beat -> o_pf=0, o_vf=2, o_vf_active=1 one cycle after acceptance.
REQ-027 SHALL cover: RUN, write port 1 {valid=1, pf=3, vf=0, vf_active=0} same cycle as i_port=1 beat -> that beat gets vf=1; next i_port=1 beat gets pf=3, vf_active=0.
REQ-028 SHALL cover: write port 3 valid=0, then i_port=3 beat -> no o_valid, err_pulse high one cycle, err_cnt 0->1 (macro defined).
REQ-029 SHALL cover: continuous i_valid with o_ready low 5 cycles -> exactly one beat held stable, i_ready=0 for those cycles, no loss; o_ready high -> one beat per cycle resumes in order.
REQ-030 SHALL cover: rst_n asserted while o_valid=1 -> o_valid=0 asynchronously; INIT reruns and the table returns to defaults (port 1 again maps vf=1).
REQ-031 SHALL cover: NUM_PORT=3, i_port=3 beat -> dropped with err_pulse; 65537 drops -> err_cnt saturated at 16'hFFFF.

Source files
------------

// File: rtl/pf_vf_port_encoder.sv
// pf_vf_port_encoder: reverse routing table that tags ingress beats from a
// mux port with the PF/VF that owns that port (inverse of the PF/VF mux).
// After reset the table is filled with an identity map (pf=0, vf=port),
// one entry per cycle, and then stays in RUN until the next reset.
//
// Optional feature: define PF_VF_PORT_ENCODER_ERR_CNT_EN to add the
// saturating 16-bit err_cnt output counting dropped beats.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_valid/i_ready            ingress handshake (i_ready is combinational)
//   i_port, i_data             source mux port, opaque payload
//   o_valid/o_ready            egress handshake (single output register)
//   o_pf, o_vf, o_vf_active    looked-up routing fields
//   o_data                     payload copied from the accepted beat
//   wr_en, wr_port, wr_valid,
//   wr_pf, wr_vf, wr_vf_active table write port (honoured in RUN only)
//   init_done                  high while the table is live (RUN)
//   err_pulse                  one-cycle flag for a dropped unmapped beat
//   err_cnt                    saturating drop counter (optional)
module pf_vf_port_encoder #(
    parameter int unsigned NUM_PORT   = 4,
    parameter int unsigned PF_WIDTH   = 3,
    parameter int unsigned VF_WIDTH   = 11,
    parameter int unsigned DATA_WIDTH = 512,
    localparam int unsigned NID_WIDTH = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [NID_WIDTH-1:0]  i_port,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [PF_WIDTH-1:0]   o_pf,
    output logic [VF_WIDTH-1:0]   o_vf,
    output logic                  o_vf_active,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  wr_en,
    input  logic [NID_WIDTH-1:0]  wr_port,
    input  logic                  wr_valid,
    input  logic                  wr_vf_active,
    input  logic [PF_WIDTH-1:0]   wr_pf,
    input  logic [VF_WIDTH-1:0]   wr_vf,
    output logic                  init_done,
    output logic                  err_pulse
`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic                valid;
        logic [PF_WIDTH-1:0] pf;
        logic [VF_WIDTH-1:0] vf;
        logic                vf_active;
    } entry_t;

    state_t               state;
    logic [NID_WIDTH-1:0] init_idx;
    entry_t               tbl [NUM_PORT];

    logic                 port_ok_c;
    logic                 wr_ok_c;
    logic [NID_WIDTH-1:0] lkp_idx_c;
    entry_t               lkp_c;
    logic                 accept_c;
    logic                 hit_c;

    // Port numbers beyond NUM_PORT exist when NUM_PORT is not a power of two.
    assign port_ok_c = ({1'b0, i_port}  < (NID_WIDTH+1)'(NUM_PORT));
    assign wr_ok_c   = ({1'b0, wr_port} < (NID_WIDTH+1)'(NUM_PORT));
    assign lkp_idx_c = port_ok_c ? i_port : NID_WIDTH'(0);
    assign lkp_c     = tbl[lkp_idx_c];

    // init_done is low in INIT and through reset, so it gates ingress.
    assign i_ready  = init_done & (~o_valid | o_ready);
    assign accept_c = i_valid & i_ready;
    assign hit_c    = port_ok_c & lkp_c.valid;

    // Init sequencer and table storage; lookups read the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_idx  <= '0;
            init_done <= 1'b0;
            for (int p = 0; p < int'(NUM_PORT); p++) begin
                tbl[p] <= '0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    tbl[init_idx] <= {1'b1, PF_WIDTH'(0), VF_WIDTH'(init_idx), 1'b1};
                    if (init_idx == NID_WIDTH'(NUM_PORT - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_idx <= init_idx + NID_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (wr_en && wr_ok_c) begin
                        tbl[wr_port] <= {wr_valid, wr_pf, wr_vf, wr_vf_active};
                    end
                end
            endcase
        end
    end

    // Single-entry output register; accept only happens when it is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid     <= 1'b0;
            o_pf        <= '0;
            o_vf        <= '0;
            o_vf_active <= 1'b0;
            o_data      <= '0;
            err_pulse   <= 1'b0;
        end else begin
            err_pulse <= accept_c & ~hit_c;
            if (accept_c && hit_c) begin
                o_valid     <= 1'b1;
                o_pf        <= lkp_c.pf;
                o_vf        <= lkp_c.vf;
                o_vf_active <= lkp_c.vf_active;
                o_data      <= i_data;
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
    // Counts drops in step with err_pulse; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept_c && !hit_c && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pf_vf_port_encoder.sv
// Directed bench for pf_vf_port_encoder: a NUM_PORT=4 instance for the main
// flows and a NUM_PORT=3 instance for out-of-range ports and counter
// saturation.
module tb_pf_vf_port_encoder;

    localparam int unsigned DW = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    // NUM_PORT=4 instance
    logic          i_valid, i_ready, o_valid, o_ready, o_vf_active;
    logic [1:0]    i_port;
    logic [DW-1:0] i_data, o_data;
    logic [2:0]    o_pf, wr_pf;
    logic [10:0]   o_vf, wr_vf;
    logic          wr_en, wr_valid, wr_vf_active;
    logic [1:0]    wr_port;
    logic          init_done, err_pulse;
    // NUM_PORT=3 instance
    logic          i_valid3, i_ready3, o_valid3, o_ready3, o_vf_active3;
    logic [1:0]    i_port3;
    logic [DW-1:0] o_data3;
    logic [2:0]    o_pf3;
    logic [10:0]   o_vf3;
    logic          init_done3, err_pulse3;
`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
    logic [15:0]   err_cnt, err_cnt3;
`endif

    pf_vf_port_encoder #(.NUM_PORT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_port(i_port), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_pf(o_pf), .o_vf(o_vf),
        .o_vf_active(o_vf_active), .o_data(o_data),
        .wr_en(wr_en), .wr_port(wr_port), .wr_valid(wr_valid),
        .wr_vf_active(wr_vf_active), .wr_pf(wr_pf), .wr_vf(wr_vf),
        .init_done(init_done), .err_pulse(err_pulse)
`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    pf_vf_port_encoder #(.NUM_PORT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid3), .i_ready(i_ready3), .i_port(i_port3), .i_data(i_data),
        .o_valid(o_valid3), .o_ready(o_ready3), .o_pf(o_pf3), .o_vf(o_vf3),
        .o_vf_active(o_vf_active3), .o_data(o_data3),
        .wr_en(1'b0), .wr_port(2'd0), .wr_valid(1'b0),
        .wr_vf_active(1'b0), .wr_pf(3'd0), .wr_vf(11'd0),
        .init_done(init_done3), .err_pulse(err_pulse3)
`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
        , .err_cnt(err_cnt3)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] port, input logic [DW-1:0] data);
        i_valid = 1'b1;
        i_port  = port;
        i_data  = data;
        step();
        i_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [2:0] pf, input logic [10:0] vf,
                             input logic act, input logic [DW-1:0] data);
        check({tag, ".o_valid"}, DW'(o_valid), DW'(1));
        check({tag, ".o_pf"}, DW'(o_pf), DW'(pf));
        check({tag, ".o_vf"}, DW'(o_vf), DW'(vf));
        check({tag, ".o_vf_active"}, DW'(o_vf_active), DW'(act));
        check({tag, ".o_data"}, o_data, data);
    endtask

    initial begin
        rst_n = 1'b0;
        i_valid = 1'b0; i_port = '0; i_data = '0; o_ready = 1'b1;
        wr_en = 1'b0; wr_port = '0; wr_valid = 1'b0; wr_vf_active = 1'b0;
        wr_pf = '0; wr_vf = '0;
        i_valid3 = 1'b0; i_port3 = '0; o_ready3 = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst.init_done", DW'(init_done), DW'(0));
        check("rst.o_valid", DW'(o_valid), DW'(0));
        check("rst.i_ready", DW'(i_ready), DW'(0));
        check("rst.err_pulse", DW'(err_pulse), DW'(0));
        check("rst.o_data", o_data, DW'(0));

        // Release reset; a write attempted during INIT must be ignored
        rst_n = 1'b1;
        wr_en = 1'b1; wr_port = 2'd0; wr_valid = 1'b0; wr_pf = 3'd5; wr_vf = 11'd9;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("init.done_c%0d", k), DW'(init_done), DW'(k == 4));
            check($sformatf("init3.done_c%0d", k), DW'(init_done3), DW'(k >= 3));
            if (k < 4) check($sformatf("init.i_ready_c%0d", k), DW'(i_ready), DW'(0));
        end
        wr_en = 1'b0;
        check("run.i_ready", DW'(i_ready), DW'(1));

        // Default map lookups
        beat(2'd2, DW'(32'hA2));
        check_out("p2", 3'd0, 11'd2, 1'b1, DW'(32'hA2));
        check("p2.err_pulse", DW'(err_pulse), DW'(0));
        beat(2'd0, DW'(32'hA0));
        check_out("p0", 3'd0, 11'd0, 1'b1, DW'(32'hA0));

        // Write and lookup of the same entry in the same cycle
        wr_en = 1'b1; wr_port = 2'd1; wr_valid = 1'b1; wr_pf = 3'd3; wr_vf = 11'd0;
        wr_vf_active = 1'b0;
        beat(2'd1, DW'(32'hB1));
        wr_en = 1'b0;
        check_out("p1_old", 3'd0, 11'd1, 1'b1, DW'(32'hB1));
        beat(2'd1, DW'(32'hB2));
        check_out("p1_new", 3'd3, 11'd0, 1'b0, DW'(32'hB2));

        // Invalidate port 3, then its beat is dropped
        wr_en = 1'b1; wr_port = 2'd3; wr_valid = 1'b0;
        step();
        wr_en = 1'b0;
        check("inv.o_valid", DW'(o_valid), DW'(0));
        beat(2'd3, DW'(32'hC3));
        check("drop.o_valid", DW'(o_valid), DW'(0));
        check("drop.err_pulse", DW'(err_pulse), DW'(1));
        step();
        check("drop.err_pulse_clr", DW'(err_pulse), DW'(0));
        check("drop.o_valid_2", DW'(o_valid), DW'(0));
`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
        check("drop.err_cnt", DW'(err_cnt), DW'(1));
`endif

        // Backpressure: five cycles of o_ready low with i_valid held
        o_ready = 1'b0;
        i_valid = 1'b1; i_port = 2'd0; i_data = DW'(100);
        step();
        i_data = DW'(101);
        check("bp.o_valid_c1", DW'(o_valid), DW'(1));
        check("bp.o_data_c1", o_data, DW'(100));
        check("bp.i_ready_c1", DW'(i_ready), DW'(0));
        for (int k = 2; k <= 5; k++) begin
            step();
            check($sformatf("bp.o_valid_c%0d", k), DW'(o_valid), DW'(1));
            check($sformatf("bp.o_data_c%0d", k), o_data, DW'(100));
            check($sformatf("bp.i_ready_c%0d", k), DW'(i_ready), DW'(0));
        end
        o_ready = 1'b1;
        #1;
        check("bp.i_ready_release", DW'(i_ready), DW'(1));
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("bp.o_valid_r%0d", k), DW'(o_valid), DW'(1));
            check($sformatf("bp.o_data_r%0d", k), o_data, DW'(100 + k));
            i_data = DW'(100 + k + 1);
        end
        i_valid = 1'b0;
        step();
        check("bp.drain", DW'(o_valid), DW'(0));

        // Asynchronous reset while a beat is held
        o_ready = 1'b0;
        beat(2'd2, DW'(32'hD2));
        check("mid.o_valid_pre", DW'(o_valid), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.o_valid", DW'(o_valid), DW'(0));
        check("mid.init_done", DW'(init_done), DW'(0));
        check("mid.i_ready", DW'(i_ready), DW'(0));
        check("mid.o_data", o_data, DW'(0));
        step();
        rst_n = 1'b1;
        o_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("reinit.done_c%0d", k), DW'(init_done), DW'(k == 4));
        end
`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
        check("reinit.err_cnt", DW'(err_cnt), DW'(0));
`endif
        beat(2'd1, DW'(32'hE1));
        check_out("reinit.p1", 3'd0, 11'd1, 1'b1, DW'(32'hE1));
        beat(2'd3, DW'(32'hE3));
        check_out("reinit.p3", 3'd0, 11'd3, 1'b1, DW'(32'hE3));

        // NUM_PORT=3: port 3 is out of range
        i_valid3 = 1'b1; i_port3 = 2'd3; i_data = DW'(32'hF3);
        step();
        i_valid3 = 1'b0;
        check("n3.drop_o_valid", DW'(o_valid3), DW'(0));
        check("n3.drop_err_pulse", DW'(err_pulse3), DW'(1));
        i_valid3 = 1'b1; i_port3 = 2'd2; i_data = DW'(32'hF2);
        step();
        i_valid3 = 1'b0;
        check("n3.p2_o_valid", DW'(o_valid3), DW'(1));
        check("n3.p2_o_vf", DW'(o_vf3), DW'(2));
        check("n3.p2_o_data", o_data3, DW'(32'hF2));
        check("n3.p2_err_pulse", DW'(err_pulse3), DW'(0));
`ifdef PF_VF_PORT_ENCODER_ERR_CNT_EN
        check("n3.err_cnt_1", DW'(err_cnt3), DW'(1));
        i_valid3 = 1'b1; i_port3 = 2'd3;
        repeat (65533) step();
        check("n3.err_cnt_65534", DW'(err_cnt3), DW'(16'hFFFE));
        repeat (4) step();
        i_valid3 = 1'b0;
        step();
        check("n3.err_cnt_sat", DW'(err_cnt3), DW'(16'hFFFF));
        check("n3.err_pulse_clr", DW'(err_pulse3), DW'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
